// File: rtl/instruction_prefetch_unit.sv
// Instruction prefetch unit: issues in-order fetch requests into a small
// circular buffer, fills entries from in-order memory responses, and feeds
// the decode-stage registers. Redirects flush the buffer and count the
// responses that are still in flight so they can be discarded.
module instruction_prefetch_unit #(
  parameter int unsigned           WORD_WIDTH = 32,
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  PCSrcE,
  input  logic [ADDR_WIDTH-1:0] PCTargetE,
  input  logic                  StallD,
  output logic                  imem_req_valid,
  output logic [ADDR_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_req_ready,
  input  logic                  imem_resp_valid,
  input  logic [WORD_WIDTH-1:0] imem_resp_data,
  output logic [WORD_WIDTH-1:0] instrD,
  output logic [ADDR_WIDTH-1:0] PCD,
  output logic [ADDR_WIDTH-1:0] PCPlus4D,
  output logic                  validD
);

  localparam int unsigned    PW        = $clog2(DEPTH);
  localparam int unsigned    CW        = PW + 1;
  localparam logic [CW:0]    DEPTH_EXT = (CW+1)'(DEPTH);

  // Buffer storage; entries are only read once marked filled, so no reset.
  logic [ADDR_WIDTH-1:0] pc_mem   [DEPTH];
  logic [WORD_WIDTH-1:0] data_mem [DEPTH];

  logic [DEPTH-1:0]      filled_q, filled_d;
  logic [PW-1:0]         head_q, head_d;
  logic [PW-1:0]         tail_q, tail_d;
  logic [PW-1:0]         fill_ptr_q, fill_ptr_d;
  // count: filled + reserved entries; pend: reserved but unfilled entries
  logic [CW-1:0]         count_q, count_d;
  logic [CW-1:0]         pend_q, pend_d;
  // Responses still owed to requests issued before the last redirect.
  logic [CW-1:0]         drop_q, drop_d;
  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;

  logic [WORD_WIDTH-1:0] instr_q, instr_d;
  logic [ADDR_WIDTH-1:0] pcd_q, pcd_d;
  logic [ADDR_WIDTH-1:0] pcp4_q, pcp4_d;
  logic                  valid_q, valid_d;

  logic [CW:0]           occ_total;
  logic [CW-1:0]         outstanding;
  logic                  req_fire;
  logic                  head_ready;
  logic                  pop;
  logic                  fill;

  // Stale in-flight requests count against capacity, so the memory never
  // holds more than DEPTH requests and the drop counter cannot overflow.
  assign occ_total      = {1'b0, count_q} + {1'b0, drop_q};
  assign imem_req_valid = reset & ~PCSrcE & (occ_total < DEPTH_EXT);
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid & imem_req_ready;

  assign head_ready = (count_q != '0) & filled_q[head_q];
  assign pop        = ~PCSrcE & ~StallD & head_ready;
  assign fill       = ~PCSrcE & imem_resp_valid & (drop_q == '0) & (pend_q != '0);

  assign instrD   = instr_q;
  assign PCD      = pcd_q;
  assign PCPlus4D = pcp4_q;
  assign validD   = valid_q;

  // Next-state for pointers, counters, fetch PC and decode registers.
  always_comb begin
    filled_d    = filled_q;
    head_d      = head_q;
    tail_d      = tail_q;
    fill_ptr_d  = fill_ptr_q;
    count_d     = count_q;
    pend_d      = pend_q;
    drop_d      = drop_q;
    fetch_pc_d  = fetch_pc_q;
    instr_d     = instr_q;
    pcd_d       = pcd_q;
    pcp4_d      = pcp4_q;
    valid_d     = valid_q;
    outstanding = pend_q + drop_q;

    if (PCSrcE) begin
      // A response landing in the redirect cycle is already stale.
      if (imem_resp_valid && (outstanding != '0)) begin
        outstanding = outstanding - CW'(1);
      end
      drop_d     = outstanding;
      filled_d   = '0;
      head_d     = '0;
      tail_d     = '0;
      fill_ptr_d = '0;
      count_d    = '0;
      pend_d     = '0;
      fetch_pc_d = PCTargetE;
      valid_d    = 1'b0;
    end else begin
      if (imem_resp_valid && (drop_q != '0)) begin
        drop_d = drop_q - CW'(1);
      end
      if (pop) begin
        filled_d[head_q] = 1'b0;
        head_d           = head_q + PW'(1);
        instr_d          = data_mem[head_q];
        pcd_d            = pc_mem[head_q];
        pcp4_d           = pc_mem[head_q] + ADDR_WIDTH'(4);
        valid_d          = 1'b1;
      end else if (!StallD) begin
        valid_d = 1'b0;
      end
      if (fill) begin
        filled_d[fill_ptr_q] = 1'b1;
        fill_ptr_d           = fill_ptr_q + PW'(1);
      end
      if (req_fire) begin
        filled_d[tail_q] = 1'b0;
        tail_d           = tail_q + PW'(1);
        fetch_pc_d       = fetch_pc_q + ADDR_WIDTH'(4);
      end
      count_d = count_q + CW'(req_fire) - CW'(pop);
      pend_d  = pend_q + CW'(req_fire) - CW'(fill);
    end
  end

  // Control state and decode registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      filled_q   <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      fill_ptr_q <= '0;
      count_q    <= '0;
      pend_q     <= '0;
      drop_q     <= '0;
      fetch_pc_q <= RESET_PC;
      instr_q    <= '0;
      pcd_q      <= '0;
      pcp4_q     <= '0;
      valid_q    <= 1'b0;
    end else begin
      filled_q   <= filled_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      fill_ptr_q <= fill_ptr_d;
      count_q    <= count_d;
      pend_q     <= pend_d;
      drop_q     <= drop_d;
      fetch_pc_q <= fetch_pc_d;
      instr_q    <= instr_d;
      pcd_q      <= pcd_d;
      pcp4_q     <= pcp4_d;
      valid_q    <= valid_d;
    end
  end

  // Buffer payload writes: PC on reservation, word on fill.
  always_ff @(posedge clk) begin
    if (req_fire) begin
      pc_mem[tail_q] <= fetch_pc_q;
    end
    if (fill) begin
      data_mem[fill_ptr_q] <= imem_resp_data;
    end
  end

endmodule

// File: tb/tb_instruction_prefetch_unit.sv
// Bench for instruction_prefetch_unit: a 32-bit and an 8-bit address instance
// share stimulus; a queue-based reference model predicts both.
module tb_instruction_prefetch_unit;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
    logic        filled;
  } ent_t;

  typedef struct packed {
    logic [31:0] data;
    int          due;
  } mreq_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        PCSrcE = 1'b0;
  logic        StallD = 1'b0;
  logic        imem_req_ready = 1'b0;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] PCTargetE = '0;
  logic [31:0] imem_resp_data = '0;
  logic [7:0]  tgt8;

  logic        rv32, vd32, rv8, vd8;
  logic [31:0] ra32, i32, pcd32, pcp32, i8;
  logic [7:0]  ra8, pcd8, pcp8;

  assign tgt8 = PCTargetE[7:0];

  always #5 clk = ~clk;

  instruction_prefetch_unit #(
    .WORD_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(DEPTH), .RESET_PC(32'h0)
  ) dut (
    .clk(clk), .reset(reset), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .StallD(StallD),
    .imem_req_valid(rv32), .imem_req_addr(ra32), .imem_req_ready(imem_req_ready),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .instrD(i32), .PCD(pcd32), .PCPlus4D(pcp32), .validD(vd32)
  );

  instruction_prefetch_unit #(
    .WORD_WIDTH(32), .ADDR_WIDTH(8), .DEPTH(DEPTH), .RESET_PC(8'h0)
  ) dut8 (
    .clk(clk), .reset(reset), .PCSrcE(PCSrcE), .PCTargetE(tgt8), .StallD(StallD),
    .imem_req_valid(rv8), .imem_req_addr(ra8), .imem_req_ready(imem_req_ready),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .instrD(i8), .PCD(pcd8), .PCPlus4D(pcp8), .validD(vd8)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int last_due = 0;
  int lat_lo = 1, lat_hi = 1;
  bit resp_gaps = 0;
  int fire_cnt = 0;

  // Reference model state.
  ent_t        m_buf[$];
  mreq_t       mem_q[$];
  int          m_drop = 0;
  logic [31:0] m_pc = '0;
  logic [31:0] e_instr = '0, e_pc = '0, e_pcp = '0;
  logic        e_valid = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int unfilled();
    int n = 0;
    foreach (m_buf[k]) if (!m_buf[k].filled) n++;
    return n;
  endfunction

  task automatic chk_decode();
    chk("validD", 32'(vd32), 32'(e_valid));
    chk("PCD", pcd32, e_pc);
    chk("PCPlus4D", pcp32, e_pcp);
    chk("instrD", i32, e_instr);
    chk("validD8", 32'(vd8), 32'(e_valid));
    chk("PCD8", 32'(pcd8), 32'(e_pc[7:0]));
    chk("PCPlus4D8", 32'(pcp8), 32'(e_pcp[7:0]));
    chk("instrD8", i8, e_instr);
  endtask

  // One clock cycle: drive inputs, check request side, advance model, check decode side.
  task automatic step(input bit pcsrc, input logic [31:0] tgt, input bit stall, input bit rdy);
    bit          exp_rv, fire, resp, pop, done;
    int          n, lat, due;
    ent_t        e;
    mreq_t       mr;
    logic [31:0] rdata;
    PCSrcE         = pcsrc;
    PCTargetE      = tgt;
    StallD         = stall;
    imem_req_ready = rdy;
    resp = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
    if (resp && resp_gaps && ($urandom_range(3) == 0)) resp = 1'b0;
    rdata           = resp ? mem_q[0].data : $urandom();
    imem_resp_valid = resp;
    imem_resp_data  = rdata;
    exp_rv = !pcsrc && ((m_buf.size() + m_drop) < DEPTH);
    #1;
    chk("req_valid", 32'(rv32), 32'(exp_rv));
    chk("req_valid8", 32'(rv8), 32'(exp_rv));
    if (exp_rv) begin
      chk("req_addr", ra32, m_pc);
      chk("req_addr8", 32'(ra8), 32'(m_pc[7:0]));
    end
    if (rv32 && rdy) fire_cnt++;
    fire = exp_rv && rdy;
    @(posedge clk);
    cyc++;
    if (resp) void'(mem_q.pop_front());
    if (pcsrc) begin
      n = m_drop + unfilled();
      if (resp && n > 0) n--;
      m_drop = n;
      m_buf.delete();
      m_pc    = tgt;
      e_valid = 1'b0;
    end else begin
      pop = !stall && (m_buf.size() > 0) && m_buf[0].filled;
      if (resp) begin
        if (m_drop > 0) begin
          m_drop--;
        end else begin
          done = 1'b0;
          for (int k = 0; k < m_buf.size(); k++) begin
            if (!done && !m_buf[k].filled) begin
              e = m_buf[k];
              e.data = rdata;
              e.filled = 1'b1;
              m_buf[k] = e;
              done = 1'b1;
            end
          end
        end
      end
      if (pop) begin
        e       = m_buf.pop_front();
        e_instr = e.data;
        e_pc    = e.pc;
        e_pcp   = e.pc + 32'd4;
        e_valid = 1'b1;
      end else if (!stall) begin
        e_valid = 1'b0;
      end
      if (fire) begin
        e.pc = m_pc;
        e.data = '0;
        e.filled = 1'b0;
        m_buf.push_back(e);
        m_pc = m_pc + 32'd4;
        lat = $urandom_range(lat_hi, lat_lo);
        due = cyc + lat - 1;
        if (due < last_due) due = last_due;
        last_due = due;
        mr.data = $urandom();
        mr.due  = due;
        mem_q.push_back(mr);
      end
    end
    #1;
    chk_decode();
  endtask

  // Assert reset mid-cycle, check the asynchronous clear, keep memory draining.
  task automatic do_reset(input int cycles);
    bit resp;
    reset          = 1'b0;
    PCSrcE         = 1'b0;
    StallD         = 1'b0;
    imem_req_ready = 1'b0;
    #1;
    chk("rst_req_valid", 32'(rv32), 32'd0);
    chk("rst_req_valid8", 32'(rv8), 32'd0);
    m_buf.delete();
    m_drop  = 0;
    m_pc    = '0;
    e_valid = 1'b0;
    e_instr = '0;
    e_pc    = '0;
    e_pcp   = '0;
    chk_decode();
    repeat (cycles) begin
      resp = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
      imem_resp_valid = resp;
      imem_resp_data  = resp ? mem_q[0].data : 32'h0;
      @(posedge clk);
      cyc++;
      if (resp) void'(mem_q.pop_front());
      #1;
    end
    imem_resp_valid = 1'b0;
    reset = 1'b1;
  endtask

  task automatic wait_valid(input string tag);
    int k = 0;
    while (!vd32 && k < 30) begin
      step(1'b0, 32'h0, 1'b0, 1'b1);
      k++;
    end
    chk(tag, 32'(vd32), 32'd1);
  endtask

  initial begin
    int k;
    #2;
    do_reset(3);

    // Zero-wait streaming from the reset PC.
    lat_lo = 1; lat_hi = 1; resp_gaps = 0;
    for (int i = 1; i <= 12; i++) begin
      step(1'b0, 32'h0, 1'b0, 1'b1);
      if (i >= 3) begin
        chk("stream_valid", 32'(vd32), 32'd1);
        chk("stream_pcd", pcd32, 32'((i - 3) * 4));
        chk("stream_pcp4", pcp32, 32'((i - 3) * 4 + 4));
      end
    end

    // Redirect together with a response while decode is stalled.
    step(1'b1, 32'h200, 1'b1, 1'b1);
    chk("redir_stall_valid", 32'(vd32), 32'd0);
    wait_valid("redir_stall_wait");
    chk("redir_stall_pcd", pcd32, 32'h200);

    // Redirect with three requests in flight at latency 3.
    lat_lo = 3; lat_hi = 3;
    do_reset(2);
    repeat (3) step(1'b0, 32'h0, 1'b1, 1'b1);
    step(1'b1, 32'h100, 1'b1, 1'b0);
    wait_valid("redir_wait");
    chk("redir_pcd", pcd32, 32'h100);

    // Address wrap in the 8-bit instance.
    lat_lo = 1; lat_hi = 1;
    step(1'b1, 32'hFC, 1'b0, 1'b1);
    wait_valid("wrap_wait_fc");
    chk("wrap_pcd8_fc", 32'(pcd8), 32'hFC);
    chk("wrap_pcp8_fc", 32'(pcp8), 32'h00);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    wait_valid("wrap_wait_00");
    chk("wrap_pcd8_00", 32'(pcd8), 32'h00);

    // Backpressure: ten stalled cycles from empty.
    do_reset(2);
    fire_cnt = 0;
    repeat (10) step(1'b0, 32'h0, 1'b1, 1'b1);
    chk("bp_fires", 32'(fire_cnt), 32'd4);
    chk("bp_req_valid", 32'(rv32), 32'd0);
    chk("bp_hold_valid", 32'(vd32), 32'd0);
    k = 0;
    repeat (12) begin
      step(1'b0, 32'h0, 1'b0, 1'b1);
      if (vd32) begin
        chk("bp_order", pcd32, 32'(k * 4));
        k++;
      end
    end
    chk("bp_count", 32'(k >= 4), 32'd1);

    // Mid-stream reset with two requests outstanding.
    lat_lo = 3; lat_hi = 3;
    repeat (3) step(1'b0, 32'h0, 1'b1, 1'b0);
    repeat (2) step(1'b0, 32'h0, 1'b1, 1'b1);
    do_reset(1);
    #1;
    chk("rst_first_valid", 32'(rv32), 32'd1);
    chk("rst_first_addr", ra32, 32'h0);
    repeat (3) step(1'b0, 32'h0, 1'b0, 1'b0);
    repeat (8) step(1'b0, 32'h0, 1'b0, 1'b1);

    // Randomized traffic.
    lat_lo = 1; lat_hi = 4; resp_gaps = 1;
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset(1);
      step($urandom_range(19) == 0, $urandom() & 32'hFFFF_FFFC,
           $urandom_range(2) == 0, $urandom_range(3) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/instruction_prefetch_unit.md
INSTRUCTION_PREFETCH_UNIT -- requirements
Module: instruction_prefetch_unit

Interface
REQ-001 The block SHALL have parameter WORD_WIDTH, default 32: instruction width.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 32: PC and memory address width.
REQ-003 The block SHALL have parameter DEPTH, default 4: prefetch buffer entries, a power of 2 and at least 2.
REQ-004 The block SHALL have parameter RESET_PC, default 0: first fetch address.
REQ-005 The block SHALL have one clock; reset SHALL be asynchronous and active-low; the ports SHALL be named clk and reset.
REQ-006 The block SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-007 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-008 The block SHALL have port PCSrcE, input, 1 bit: redirect request from execute.
REQ-009 The block SHALL have port PCTargetE, input, ADDR_WIDTH bits: redirect target.
REQ-010 The block SHALL have port StallD, input, 1 bit: 1 holds the decode-stage registers.
REQ-011 The block SHALL have port imem_req_valid, output, 1 bit: fetch request valid.
REQ-012 The block SHALL have port imem_req_addr, output, ADDR_WIDTH bits: fetch byte address.
REQ-013 The block SHALL have port imem_req_ready, input, 1 bit: memory accepts the request.
REQ-014 The block SHALL have port imem_resp_valid, input, 1 bit: response valid; responses return in request order with latency of 1 or more cycles.
REQ-015 The block SHALL have port imem_resp_data, input, WORD_WIDTH bits: instruction word.
REQ-016 The block SHALL have port instrD, output, WORD_WIDTH bits: decode instruction.
REQ-017 The block SHALL have ports PCD and PCPlus4D, output, ADDR_WIDTH bits each: PC of the decode instruction and that PC + 4.
REQ-018 The block SHALL have port validD, output, 1 bit: decode registers hold a real instruction.

Function
REQ-019 A request SHALL transfer only when imem_req_valid and imem_req_ready are both 1; imem_req_addr SHALL equal the fetch PC.
REQ-020 imem_req_valid SHALL be 1 only when buffer occupancy (filled plus reserved entries) is below DEPTH and PCSrcE is 0.
REQ-021 Each transferred request SHALL reserve the tail buffer entry with its PC marked unfilled, and SHALL advance the fetch PC by 4, modulo 2^ADDR_WIDTH.
REQ-022 Each accepted response SHALL fill the oldest unfilled entry with imem_resp_data.
REQ-023 A response that arrives when no entry is unfilled and the drop counter is 0 SHALL be ignored.
REQ-024 When StallD is 0 and the head entry is filled, the block SHALL load instrD, PCD and PCPlus4D from the head entry, set validD to 1, and pop the head entry.
REQ-025 When StallD is 0 and the head entry is empty or unfilled, the block SHALL set validD to 0 and hold the other decode outputs.
REQ-026 When StallD is 1 and PCSrcE is 0, all decode outputs SHALL hold.
REQ-027 A reservation, a fill and a pop SHALL all be allowed in the same cycle, including when the buffer is full or when the fill targets the head entry (fill-to-pop bypass is not required; the filled entry pops next cycle).
REQ-028 When PCSrcE is 1, the next fetch PC SHALL be PCTargetE.
REQ-029 When PCSrcE is 1, the buffer SHALL be cleared and validD SHALL be set to 0, taking priority over StallD.
REQ-030 When PCSrcE is 1, no request SHALL be issued in that cycle.
REQ-031 On redirect, the drop counter SHALL be set to the number of requests still outstanding after that cycle's response is counted; a response arriving in the redirect cycle SHALL be discarded.
REQ-032 While the drop counter is nonzero, each response SHALL be discarded and SHALL decrement the counter.
REQ-033 A redirect that occurs while the drop counter is nonzero SHALL add the current outstanding requests to the counter.
REQ-034 Requests issued after a redirect SHALL be allowed while the drop counter is nonzero.
REQ-035 The total of outstanding and reserved entries SHALL never exceed DEPTH.
REQ-036 All counters SHALL be log2(DEPTH)+1 bits wide.

Reset
REQ-037 While reset is 0, the block SHALL asynchronously set the fetch PC to RESET_PC and clear the buffer and drop counter.
REQ-038 While reset is 0, the block SHALL asynchronously set instrD, PCD, PCPlus4D and validD to 0, and force imem_req_valid to 0.
REQ-039 imem_req_valid SHALL assert on the first rising edge after reset returns to 1.
REQ-040 A reset that occurs with requests outstanding SHALL forget them; responses after reset SHALL fill nothing until new requests are issued.

Verification
REQ-041 Zero-wait streaming: with ready=1 and 1-cycle responses from 0x0, the bench SHALL check validD=1 each cycle and PCD 0x0, 0x4, 0x8, … with PCPlus4D=PCD+4.
REQ-042 Backpressure: with StallD=1 for 10 cycles, the bench SHALL check that exactly 4 requests issue (DEPTH=4), then req_valid=0 and the outputs hold; after release, it SHALL check in-order delivery with no loss.
REQ-043 Redirect with 3 outstanding at latency 3 and PCTargetE=0x100: the bench SHALL check that the 3 stale responses are dropped, the next validD shows PCD=0x100, and no stale word appears.
REQ-044 Redirect coinciding with a response and StallD=1: the bench SHALL check validD=0 next cycle and that the response is discarded.
REQ-045 Wrap: with ADDR_WIDTH=8 and redirect to 0xFC, the bench SHALL check the PCD sequence 0xFC, 0x00, and PCPlus4D=0x00 for 0xFC.
REQ-046 Mid-stream reset: asserting reset with 2 outstanding, the bench SHALL check that all outputs read 0 immediately and that, after release, the first request address is RESET_PC.
